pool2d_engine: RTL and testbench
================================

# pool2d_engine

Parametrised 2-D pooling engine for the image path: reads a channel-planar feature map from an external synchronous RAM, reduces each KSIZE×KSIZE window at stride STRIDE by signed max or rounded average, and emits one pooled value per window over a valid/ready output. It sits between a conv stage's output buffer and the next layer's input buffer. It generalises the fixed 3×3/stride-2 max-pool with runtime mode, multi-channel sweep, start/done control and output backpressure.

## Interface
- DATW, 16: sample width, signed two's complement
- IN_SIZE, 111: input map side (square)
- OUT_SIZE, 55: output map side; elaboration error unless (OUT_SIZE-1)*STRIDE+KSIZE <= IN_SIZE
- KSIZE, 3: window side, 1..7
- STRIDE, 2: window step, >= 1
- CHANNELS, 1: channel planes swept per run
- ADDRW, 32: RAM address width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle run request, honoured only in IDLE
- mode  in  1  0 = max, 1 = average; sampled with start, held for the run
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the last output handshake
- address  out  ADDRW  RAM read address
- rd_en  out  1  RAM read strobe
- datain  in  DATW  RAM read data, valid the cycle after rd_en
- out_data  out  DATW  pooled value
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accept
- out_last  out  1  high with the final output of the run

## Operation
- States: IDLE, READ, WAIT, EMIT, DONE. IDLE→READ on start; READ→WAIT after KSIZE*KSIZE reads; WAIT→EMIT always; EMIT→READ on handshake when outputs remain, EMIT→DONE on handshake of last output; DONE→IDLE after one cycle, with done=1.
- Counters: kx, ky (window), ox, oy (output), ch (channel). kx fastest, then ky; after emit ox, then oy, then ch. Row-major output order, channel outermost.
- address = ch*IN_SIZE*IN_SIZE + (oy*STRIDE+ky)*IN_SIZE + ox*STRIDE+kx, computed in ADDRW bits, driven only in READ with rd_en=1; address holds and rd_en=0 elsewhere.
- Reduction: first datum of window loads accumulator; later data fold in. Max: signed compare. Average: signed sum, accumulator width DATW+clog2(KSIZE*KSIZE); result = (sum*RECIP + 2^15) >>> 16, RECIP = round(65536/(KSIZE*KSIZE)); truncated to DATW.
- Result registered into out_data at WAIT exit; out_data/out_valid/out_last stable until out_ready. No reads while in EMIT.
- start outside IDLE ignored; mode change mid-run ignored.
- Reset (any time): state IDLE, all counters 0, busy=0, done=0, rd_en=0, address=0, out_valid=0, out_data=0, out_last=0. No partial output survives.

## Timing
- Start sampled at edge E; first rd_en at cycle E+1; reads on E+1..E+K², WAIT at E+K²+1, out_valid first high at E+K²+2.
- Per-window cost K²+2 cycles plus stall cycles with out_ready low; handshake cycle counts as EMIT, next READ starts the following cycle.
- done pulses the cycle after the final handshake; busy falls same cycle as done.

## Structure
- Package pool_pkg: mode encoding (POOL_MAX, POOL_AVG), state typedef, function for RECIP and accumulator width.
- Sub-module pool_window_reduce: accumulator with first/fold/mode inputs and result output; engine owns FSM, counters and address generation.

## Test plan
- 5×5, K=3, S=2, OUT=2, CH=1, RAM[i]=i, mode 0 -> outputs 12, 14, 22, 24; out_last on 24; done once; 4 × 9 reads, addresses 0,1,2,5,6,7,10,11,12 for first window.
- Same map, mode 1 -> first output 6 (sum 54); all-(-1) map -> every output -1; all-(-5) map mode 0 -> -5.
- CH=2, second plane RAM[25+i]=100+i, mode 0 -> 12,14,22,24,112,114,122,124; first ch1 address 25.
- out_ready low 10 cycles on second output -> out_data/out_valid stable, rd_en=0, address unchanged; resumes correctly on release.
- start pulsed during READ and EMIT -> ignored, output sequence unchanged; start held high after done -> new run.
- rst asserted mid-READ of second window -> all outputs zero immediately (async), FSM IDLE; fresh start reproduces the full sequence from output 12.

Source files
------------

// File: rtl/pool2d_engine_pkg.sv
// Shared types and elaboration helpers for the 2-D pooling engine.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } pool_state_e;

  // Fixed-point reciprocal of the window area, Q16, rounded to nearest.
  function automatic int recip(input int ksize);
    return (65536 + (ksize * ksize) / 2) / (ksize * ksize);
  endfunction

  // Width that holds a signed sum of ksize*ksize samples without overflow.
  function automatic int acc_width(input int datw, input int ksize);
    return datw + $clog2(ksize * ksize);
  endfunction

endpackage

// File: rtl/pool2d_engine_if.sv
// RAM read port plus pooled-output stream of the pooling engine.
interface pool2d_engine_if #(
  parameter int DATW  = 16,
  parameter int ADDRW = 32
);
  logic [ADDRW-1:0]       address;
  logic                   rd_en;
  logic signed [DATW-1:0] datain;
  logic signed [DATW-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;

  modport master (
    output address, rd_en, out_data, out_valid, out_last,
    input  datain, out_ready
  );

  modport slave (
    input  address, rd_en, out_data, out_valid, out_last,
    output datain, out_ready
  );
endinterface

// File: rtl/pool2d_engine_window_reduce.sv
// Window accumulator: signed max or Q16-scaled rounded average; result is combinational
// on the incoming datum so the last sample of a window is included without an extra cycle.
module pool_window_reduce
  import pool_pkg::*;
#(
  parameter int DATW  = 16,
  parameter int KSIZE = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vld,
  input  logic                   first,
  input  pool_mode_e             mode,
  input  logic signed [DATW-1:0] din,
  output logic signed [DATW-1:0] result
);
  localparam int AW = acc_width(DATW, KSIZE);
  localparam int PW = DATW + 16;
  localparam int RC = recip(KSIZE);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_nxt;
  logic signed [AW-1:0] din_x;
  logic signed [PW-1:0] scaled;

  assign din_x = AW'(din);

  always_comb begin
    acc_nxt = acc;
    if (vld) begin
      if (first) begin
        acc_nxt = din_x;
      end else if (mode == POOL_MAX) begin
        acc_nxt = (din_x > acc) ? din_x : acc;
      end else begin
        acc_nxt = acc + din_x;
      end
    end
  end

  // Only bits [16 +: DATW] of the product survive, so PW bits of modular product suffice.
  assign scaled = PW'(acc_nxt) * PW'(RC) + PW'(32768);
  assign result = (mode == POOL_AVG) ? DATW'(scaled >>> 16) : DATW'(acc_nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= acc_nxt;
    end
  end
endmodule

// File: rtl/pool2d_engine.sv
// Sweeps KSIZE x KSIZE windows at STRIDE over a channel-planar RAM map, one pooled value per window.
// K*K+2 cycles per window; the output holds while out_ready is low and no RAM reads are issued then.
module pool2d_engine
  import pool_pkg::*;
#(
  parameter int DATW     = 16,
  parameter int IN_SIZE  = 111,
  parameter int OUT_SIZE = 55,
  parameter int KSIZE    = 3,
  parameter int STRIDE   = 2,
  parameter int CHANNELS = 1,
  parameter int ADDRW    = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic mode,
  output logic busy,
  output logic done,
  pool2d_engine_if.master bus
);
  localparam int KW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int OW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  if (KSIZE < 1 || KSIZE > 7) begin : g_bad_ksize
    $error("pool2d_engine: KSIZE must be within 1..7");
  end
  if (STRIDE < 1) begin : g_bad_stride
    $error("pool2d_engine: STRIDE must be at least 1");
  end
  if ((OUT_SIZE - 1) * STRIDE + KSIZE > IN_SIZE) begin : g_bad_geometry
    $error("pool2d_engine: window sweep runs past the input map");
  end

  pool_state_e            state;
  pool_state_e            state_nxt;
  pool_mode_e             mode_q;
  logic [KW-1:0]          kx;
  logic [KW-1:0]          ky;
  logic [OW-1:0]          ox;
  logic [OW-1:0]          oy;
  logic [CW-1:0]          ch;
  logic [ADDRW-1:0]       addr_calc;
  logic [ADDRW-1:0]       addr_q;
  logic                   win_end;
  logic                   last_win;
  logic                   handshake;
  logic                   d_vld;
  logic                   d_first;
  logic signed [DATW-1:0] red_result;

  assign win_end   = (kx == KW'(KSIZE - 1)) && (ky == KW'(KSIZE - 1));
  assign last_win  = (ox == OW'(OUT_SIZE - 1)) && (oy == OW'(OUT_SIZE - 1)) &&
                     (ch == CW'(CHANNELS - 1));
  assign handshake = (state == EMIT) && bus.out_ready;

  always_comb begin
    addr_calc = ADDRW'(ch) * ADDRW'(IN_SIZE * IN_SIZE)
              + (ADDRW'(oy) * ADDRW'(STRIDE) + ADDRW'(ky)) * ADDRW'(IN_SIZE)
              + ADDRW'(ox) * ADDRW'(STRIDE) + ADDRW'(kx);
  end

  // Outside READ the last issued address is held rather than tracking the counters.
  assign bus.address = (state == READ) ? addr_calc : addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    done          = 1'b0;
    bus.rd_en     = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = READ;
      end
      READ: begin
        busy      = 1'b1;
        bus.rd_en = 1'b1;
        if (win_end) state_nxt = WAIT;
      end
      WAIT: begin
        busy      = 1'b1;
        state_nxt = EMIT;
      end
      EMIT: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = bus.out_last ? DONE : READ;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q       <= POOL_MAX;
      kx           <= '0;
      ky           <= '0;
      ox           <= '0;
      oy           <= '0;
      ch           <= '0;
      addr_q       <= '0;
      d_vld        <= 1'b0;
      d_first      <= 1'b0;
      bus.out_data <= '0;
      bus.out_last <= 1'b0;
    end else begin
      // RAM data lags rd_en by one cycle, so the reducer controls are delayed to match.
      d_vld   <= (state == READ);
      d_first <= (state == READ) && (kx == '0) && (ky == '0);
      case (state)
        IDLE: begin
          if (start) mode_q <= pool_mode_e'(mode);
        end
        READ: begin
          addr_q <= addr_calc;
          if (kx == KW'(KSIZE - 1)) begin
            kx <= '0;
            ky <= win_end ? '0 : ky + KW'(1);
          end else begin
            kx <= kx + KW'(1);
          end
        end
        WAIT: begin
          bus.out_data <= red_result;
          bus.out_last <= last_win;
        end
        EMIT: begin
          if (handshake) begin
            bus.out_last <= 1'b0;
            if (ox == OW'(OUT_SIZE - 1)) begin
              ox <= '0;
              if (oy == OW'(OUT_SIZE - 1)) begin
                oy <= '0;
                ch <= (ch == CW'(CHANNELS - 1)) ? '0 : ch + CW'(1);
              end else begin
                oy <= oy + OW'(1);
              end
            end else begin
              ox <= ox + OW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  pool_window_reduce #(
    .DATW  (DATW),
    .KSIZE (KSIZE)
  ) u_reduce (
    .clk    (clk),
    .rst    (rst),
    .vld    (d_vld),
    .first  (d_first),
    .mode   (mode_q),
    .din    (bus.datain),
    .result (red_result)
  );
endmodule

// File: tb/tb_pool2d_engine.sv
// Directed runs of the pooling engine against a window-level reference model and a RAM model.
module tb_pool2d_engine;
  localparam int DATW  = 16;
  localparam int IN    = 5;
  localparam int OUT   = 2;
  localparam int K     = 3;
  localparam int S     = 2;
  localparam int CH    = 2;
  localparam int ADDRW = 32;
  localparam int NWIN  = OUT * OUT * CH;
  localparam int NRAM  = IN * IN * CH;
  localparam longint RECIP = longint'(65536.0 / real'(K * K));

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic mode  = 1'b0;
  logic busy;
  logic done;
  logic signed [DATW-1:0] ram [NRAM];
  int ncmp  = 0;
  int nfail = 0;

  pool2d_engine_if #(.DATW(DATW), .ADDRW(ADDRW)) bus ();

  pool2d_engine #(
    .DATW(DATW), .IN_SIZE(IN), .OUT_SIZE(OUT), .KSIZE(K),
    .STRIDE(S), .CHANNELS(CH), .ADDRW(ADDRW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.rd_en) bus.datain <= ram[int'(bus.address)];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [DATW-1:0] ref_win(input int c, input int wy, input int wx, input bit m);
    longint sum = 0;
    longint mx  = 0;
    longint v;
    longint q;
    for (int ky = 0; ky < K; ky++) begin
      for (int kx = 0; kx < K; kx++) begin
        v = longint'(ram[c * IN * IN + (wy * S + ky) * IN + wx * S + kx]);
        sum += v;
        if ((ky == 0 && kx == 0) || v > mx) mx = v;
      end
    end
    q = m ? ((sum * RECIP + 64'sd32768) >>> 16) : mx;
    return q[DATW-1:0];
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < NRAM; i++) ram[i] = (i < IN * IN) ? DATW'(i) : DATW'(100 + i - IN * IN);
  endtask

  task automatic fill_const(input int val);
    for (int i = 0; i < NRAM; i++) ram[i] = DATW'(val);
  endtask

  task automatic run(input bit m, input int stall_idx, input bit rnd, input bit poke,
                     input bit chain, input int abort_reads);
    logic signed [DATW-1:0] exp_q [$];
    logic [ADDRW-1:0]       addr_q [$];
    logic signed [DATW-1:0] hold_dat;
    logic [ADDRW-1:0]       hold_addr;
    int got = 0, reads = 0, dones = 0, cyc = 0, stall = 0, first_vld = 0;
    hold_dat  = '0;
    hold_addr = '0;
    for (int c = 0; c < CH; c++)
      for (int oy = 0; oy < OUT; oy++)
        for (int ox = 0; ox < OUT; ox++) begin
          exp_q.push_back(ref_win(c, oy, ox, m));
          for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
              addr_q.push_back(ADDRW'(c * IN * IN + (oy * S + ky) * IN + ox * S + kx));
        end
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
    chk("busy_after_start", busy, 1);
    while (dones == 0 && cyc < 2000) begin
      cyc++;
      start = poke && (cyc == 3 || (bus.out_valid && got == 1));
      if (cyc == 1) chk("first_rd_en", bus.rd_en, 1);
      if (bus.rd_en) begin
        reads++;
        if (addr_q.size() > 0) chk("rd_addr", bus.address, addr_q.pop_front());
        else chk("extra_read", reads, NWIN * K * K);
        if (abort_reads > 0 && reads == abort_reads) break;
      end
      if (bus.out_valid) begin
        if (first_vld == 0) begin
          first_vld = cyc;
          chk("first_valid_cycle", cyc, K * K + 2);
        end
        chk("no_read_in_emit", bus.rd_en, 0);
        if (got == stall_idx && stall < 10) begin
          if (stall == 0) begin
            hold_dat  = bus.out_data;
            hold_addr = bus.address;
          end else begin
            chk("stall_data", bus.out_data, hold_dat);
            chk("stall_addr", bus.address, hold_addr);
          end
          stall++;
          bus.out_ready = 1'b0;
        end else begin
          bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (bus.out_ready) begin
          if (got < NWIN) chk("out_data", bus.out_data, exp_q[got]);
          else chk("extra_output", got, NWIN - 1);
          chk("out_last", bus.out_last, got == NWIN - 1);
          got++;
        end
      end else begin
        if (stall > 0 && stall < 10) chk("stall_valid", bus.out_valid, 1);
        bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (done) begin
        dones++;
        chk("busy_low_at_done", busy, 0);
        chk("outputs_before_done", got, NWIN);
        if (chain) start = 1'b1;
      end
      @(negedge clk);
    end
    if (abort_reads == 0) begin
      chk("done_seen", dones, 1);
      chk("reads_total", reads, NWIN * K * K);
      chk("done_one_cycle", done, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    fill_ramp();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_address", bus.address, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    rst = 1'b0;
    @(negedge clk);

    run(1'b0, 1, 1'b0, 1'b0, 1'b0, 0);
    run(1'b1, -1, 1'b0, 1'b1, 1'b1, 0);
    fill_const(-1);
    run(1'b1, -1, 1'b0, 1'b0, 1'b0, 0);
    fill_const(-5);
    run(1'b0, -1, 1'b0, 1'b0, 1'b0, 0);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NRAM; i++) ram[i] = DATW'($urandom);
      run(1'($urandom_range(0, 1)), -1, 1'b1, 1'b0, 1'b0, 0);
    end

    fill_ramp();
    run(1'b0, -1, 1'b0, 1'b0, 1'b0, K * K + 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_rd_en", bus.rd_en, 0);
    chk("arst_address", bus.address, 0);
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_data", bus.out_data, 0);
    chk("arst_out_last", bus.out_last, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(1'b0, -1, 1'b0, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
